data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 55 +++++
 rtl/data_mem_responder_load_align.sv | 28 ++
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder: FSM states,
// RV32I load/store width codes, access checking and byte-enable generation.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_FUNCT3,
    ERR_MISALIGN,
    ERR_RANGE
  } err_code_e;

  // Range is checked by the caller, which knows the storage depth.
  function automatic err_code_e check_access(input logic       write,
                                             input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    logic legal_f3;
    logic misaligned;
    if (write) legal_f3 = funct3 inside {F3_SB, F3_SH, F3_SW};
    else       legal_f3 = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (!legal_f3)       return ERR_FUNCT3;
    else if (misaligned) return ERR_MISALIGN;
    else                 return ERR_NONE;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    case (funct3)
      F3_SB:   return 4'(4'b0001 << addr_lo);
      F3_SH:   return addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Load formatter: selects the byte/halfword lane of a memory word and
// sign- or zero-extends it according to the load width code.
module mem_load_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    byte_sh = word >> {addr_lo, 3'b000};
    half_sh = word >> {addr_lo[1], 4'b0000};
    case (funct3)
      F3_LB:   data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_LH:   data = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_LW:   data = word;
      F3_LBU:  data = {24'h0, byte_sh[7:0]};
      F3_LHU:  data = {16'h0, half_sh[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: accept a request in IDLE,
// access storage for one cycle, then hold the response until taken.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic [31:0] mem_q [DEPTH];

  err_code_e   err_code;
  logic        access_err;
  logic [AW-1:0] mem_idx;
  logic [31:0] mem_word;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic        mem_we;

  always_comb begin
    err_code = check_access(write_q, funct3_q, addr_q[1:0]);
    // No wrap-around: any upper index bit beyond the storage is an error.
    if (err_code == ERR_NONE && addr_q[31:2] >= 30'(DEPTH)) err_code = ERR_RANGE;
    access_err = (err_code != ERR_NONE);
    mem_idx    = addr_q[AW+1:2];
    be         = store_be(funct3_q, addr_q[1:0]);
    case (funct3_q[1:0])
      2'b00:   wdata_lanes = {4{wdata_q[7:0]}};
      2'b01:   wdata_lanes = {2{wdata_q[15:0]}};
      default: wdata_lanes = wdata_q;
    endcase
    mem_we = rst && (state_q == ST_ACCESS) && write_q && !access_err;
  end

  assign mem_word = mem_q[mem_idx];

  mem_load_align u_load_align (
    .word    (mem_word),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[mem_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d  = req_write;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_error_d = access_err;
        rsp_rdata_d = (write_q || access_err) ? '0 : load_data;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
